dec38_strobe_seq: RTL

//  Registered 3-to-8 one-hot decoder with strobe timing. Accepts a 3-bit code over a

---
 rtl/dec38_strobe_seq_pkg.sv | 13 +
 rtl/dec38_strobe_seq_core.sv | 14 +
 rtl/dec38_strobe_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dec38_strobe_seq_pkg.sv
// Shared definitions for the 3-to-8 strobe decoder: FSM state encodings and the
// first code of an automatic scan.
package dec38_strobe_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] SCAN_FIRST = 3'd7;

endpackage

// File: rtl/dec38_strobe_seq_core.sv
// Purely combinational 3-to-8 one-hot decode; the caller registers the result.
module dec38_core
  import dec38_strobe_seq_pkg::*;
(
  input  logic [2:0] i_code,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = 8'h00;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/dec38_strobe_seq.sv
// Registered 3-to-8 one-hot strobe sequencer: single codes over valid/ready,
// or an automatic 7..0 scan, each strobe held HOLD_CYC clocks then GAP_CYC quiet.
module dec38_strobe_seq
  import dec38_strobe_seq_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  input  logic       scan_en,
  output logic [7:0] d,
  output logic       d_valid,
  output logic       busy,
  output logic       done
);

  localparam int HOLD_EFF = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_scan_code;
  logic             r_scan;

  logic [2:0] w_dec_code;
  logic [7:0] w_onehot;
  logic       w_more_scan;

  // In IDLE the decoder sees the code about to start; otherwise the next scan code.
  always_comb begin
    w_dec_code = r_scan_code - 3'd1;
    if (r_state == ST_IDLE) begin
      w_dec_code = scan_en ? SCAN_FIRST : in_code;
    end
  end

  assign w_more_scan = r_scan && scan_en && (r_scan_code != 3'd0);

  dec38_core u_core (
    .i_code   (w_dec_code),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_scan_code <= '0;
      r_scan      <= 1'b0;
      d           <= 8'h00;
      d_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scan_en) begin
            r_scan      <= 1'b1;
            r_scan_code <= SCAN_FIRST;
            r_state     <= ST_HOLD;
            r_cnt       <= HOLD_LOAD;
            d           <= w_onehot;
            d_valid     <= 1'b1;
            busy        <= 1'b1;
            in_ready    <= 1'b0;
          end else if (in_valid && in_ready) begin
            r_scan   <= 1'b0;
            r_state  <= ST_HOLD;
            r_cnt    <= HOLD_LOAD;
            d        <= w_onehot;
            d_valid  <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            done    <= 1'b1;
            d       <= 8'h00;
            d_valid <= 1'b0;
            if (GAP_CYC != 0) begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LOAD;
            end else if (w_more_scan) begin
              // With no gap a scan moves straight on to the next code.
              r_scan_code <= r_scan_code - 3'd1;
              r_cnt       <= HOLD_LOAD;
              d           <= w_onehot;
              d_valid     <= 1'b1;
            end else begin
              r_state  <= ST_IDLE;
              r_scan   <= 1'b0;
              busy     <= 1'b0;
              in_ready <= r_scan ? ~scan_en : 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_more_scan) begin
            r_scan_code <= r_scan_code - 3'd1;
            r_state     <= ST_HOLD;
            r_cnt       <= HOLD_LOAD;
            d           <= w_onehot;
            d_valid     <= 1'b1;
          end else begin
            r_state  <= ST_IDLE;
            r_scan   <= 1'b0;
            busy     <= 1'b0;
            in_ready <= r_scan ? ~scan_en : 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_scan   <= 1'b0;
          d        <= 8'h00;
          d_valid  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
